// File: rtl/step_phase_decoder.sv
// Receive-side decoder for 4-phase full-step coil drive: synchronise, glitch-filter,
// decode phase changes into signed position, direction, step period and status.
module step_phase_decoder #(
    parameter int unsigned FILT_CYCLES = 16,
    parameter int unsigned POS_W       = 32,
    parameter int unsigned PER_W       = 24,
    parameter int unsigned TIMEOUT     = 2000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       phase_in,
    input  logic             clr,
    output logic [POS_W-1:0] pos,
    output logic             step_valid,
    output logic             step_dir,
    output logic [PER_W-1:0] period,
    output logic             period_valid,
    output logic             stalled,
    output logic             err,
    output logic [1:0]       err_code
);

    localparam int unsigned FW = $clog2(FILT_CYCLES + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic {IDLE, TRACK} state_t;

    state_t           state;
    logic [3:0]       sync1, sync2, cand, stable, ref_phase;
    logic [FW-1:0]    match_cnt, match_next;
    logic             accept, fresh, first_seen, hold;
    logic [PER_W-1:0] per_cnt;
    logic [TW-1:0]    idle_cnt;
    logic [3:0]       fwd_phase, rev_phase;
    logic             stable_oh;

    always_comb begin
        match_next = FW'(1);
        if (sync2 == cand)
            match_next = (match_cnt == FW'(FILT_CYCLES)) ? match_cnt : match_cnt + FW'(1);
        accept    = (match_next == FW'(FILT_CYCLES)) && (sync2 != stable);
        fwd_phase = {ref_phase[0], ref_phase[3:1]};
        rev_phase = {ref_phase[2:0], ref_phase[3]};
        stable_oh = (stable != 4'b0000) && ((stable & (stable - 4'd1)) == 4'b0000);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1     <= '0;
            sync2     <= '0;
            cand      <= '0;
            match_cnt <= '0;
            stable    <= '0;
            fresh     <= 1'b0;
        end else begin
            sync1     <= phase_in;
            sync2     <= sync1;
            cand      <= sync2;
            match_cnt <= match_next;
            fresh     <= accept;
            if (accept)
                stable <= sync2;
        end
    end

    // hold blocks re-adopting the pattern that just caused an error until the
    // stable pattern changes again; clr drops it so the current pattern is re-adopted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            ref_phase    <= '0;
            pos          <= '0;
            step_valid   <= 1'b0;
            step_dir     <= 1'b0;
            period       <= '0;
            period_valid <= 1'b0;
            stalled      <= 1'b0;
            err          <= 1'b0;
            err_code     <= 2'b00;
            per_cnt      <= '0;
            idle_cnt     <= '0;
            first_seen   <= 1'b0;
            hold         <= 1'b0;
        end else begin
            step_valid   <= 1'b0;
            period_valid <= 1'b0;
            if (per_cnt != '1)
                per_cnt <= per_cnt + PER_W'(1);
            if (clr) begin
                state      <= IDLE;
                pos        <= '0;
                period     <= '0;
                err        <= 1'b0;
                err_code   <= 2'b00;
                stalled    <= 1'b0;
                per_cnt    <= '0;
                idle_cnt   <= '0;
                first_seen <= 1'b0;
                hold       <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        stalled  <= 1'b0;
                        idle_cnt <= '0;
                        if (fresh)
                            hold <= 1'b0;
                        if (stable_oh && (!hold || fresh)) begin
                            ref_phase  <= stable;
                            first_seen <= 1'b0;
                            state      <= TRACK;
                        end
                    end
                    TRACK: begin
                        if (stable != ref_phase) begin
                            if (stable == fwd_phase || stable == rev_phase) begin
                                pos        <= (stable == fwd_phase) ? pos + POS_W'(1) : pos - POS_W'(1);
                                step_dir   <= (stable == fwd_phase);
                                step_valid <= 1'b1;
                                ref_phase  <= stable;
                                per_cnt    <= PER_W'(1);
                                idle_cnt   <= '0;
                                stalled    <= 1'b0;
                                first_seen <= 1'b1;
                                if (first_seen) begin
                                    period       <= per_cnt;
                                    period_valid <= 1'b1;
                                end
                            end else begin
                                err     <= 1'b1;
                                if (err_code == 2'b00)
                                    err_code <= stable_oh ? 2'b10 : 2'b01;
                                stalled <= 1'b0;
                                hold    <= 1'b1;
                                state   <= IDLE;
                            end
                        end else begin
                            if (idle_cnt != TW'(TIMEOUT))
                                idle_cnt <= idle_cnt + TW'(1);
                            if (idle_cnt >= TW'(TIMEOUT - 1))
                                stalled <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
